// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the CPU bus master: access sizes, FSM states,
// byte-lane enables, store-data steering and load-data extraction.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP,
        ST_ERR
    } bus_state_t;

    localparam int LANES  = 4;
    localparam int DATA_W = 8 * LANES;

    // Byte lanes touched by an access of the given size at byte offset a.
    function automatic logic [LANES-1:0] be_gen(input size_t size, input logic [1:0] a);
        logic [LANES-1:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = 4'b0011 << a;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Misaligned halfword/word or the reserved size code cannot go on the bus.
    function automatic logic access_err(input size_t size, input logic [1:0] a);
        logic err;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = a[0];
            SZ_W:    err = (a != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Right-justified store data copied into every lane so byteenable picks it.
    function automatic logic [DATA_W-1:0] store_steer(input logic [DATA_W-1:0] w, input size_t size);
        logic [DATA_W-1:0] d;
        case (size)
            SZ_B:    d = {4{w[7:0]}};
            SZ_H:    d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    // Pull the addressed lane out of the bus word and extend it to 32 bits.
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] rdata,
                                                       input size_t size,
                                                       input logic [1:0] a,
                                                       input logic sgn);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        case (a)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    r = {{24{sgn & b[7]}}, b};
            SZ_H:    r = {{16{sgn & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_rr_arbiter.sv
// Rotating-priority arbiter: searches the request vector starting at ptr_i
// and returns the first requester as a one-hot grant plus its index.
module mips_rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int cand;

    // Walk the channels from the pointer, wrapping, and take the first request.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mips_bus_master_arb.sv
// N-channel bus master: arbitrates CPU requesters onto one Avalon-style bus,
// runs one transaction at a time and handles sub-word lanes and extension.
module mips_bus_master_arb
    import mips_bus_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int ADDR_W      = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH-1:0]        req_valid,
    output logic [N_CH-1:0]        req_ready,
    input  logic [N_CH-1:0]        req_write,
    input  logic [2*N_CH-1:0]      req_size,
    input  logic [N_CH-1:0]        req_signed,
    input  logic [ADDR_W*N_CH-1:0] req_addr,
    input  logic [32*N_CH-1:0]     req_wdata,
    output logic [N_CH-1:0]        rsp_valid,
    output logic                   rsp_err,
    output logic [31:0]            rsp_rdata,
    output logic [ADDR_W-1:0]      address,
    output logic                   read,
    output logic                   write,
    output logic [31:0]            writedata,
    output logic [3:0]             byteenable,
    input  logic                   waitrequest,
    input  logic [31:0]            readdata,
    output logic                   busy
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    bus_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     ch_q, ch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_t             size_q, size_d;
    logic              write_q, write_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [IW-1:0]     arbPtr;
    logic [N_CH-1:0]   grant;
    logic [IW-1:0]     grantIdx;
    logic              grantAny;
    logic              idleOpen;

    logic              selWrite;
    logic [1:0]        selSize;
    logic              selSigned;
    logic [ADDR_W-1:0] selAddr;
    logic [31:0]       selWdata;

    assign arbPtr   = ROUND_ROBIN ? ptr_q : '0;
    assign idleOpen = (state_q == ST_IDLE) && !reset;
    assign req_ready = grant & {N_CH{idleOpen}};

    mips_rr_arbiter #(.N(N_CH), .IW(IW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (arbPtr),
        .grant_o (grant),
        .idx_o   (grantIdx),
        .any_o   (grantAny)
    );

    // Mux the granted channel's request fields out of the flat port vectors.
    always_comb begin
        selWrite  = 1'b0;
        selSize   = 2'b00;
        selSigned = 1'b0;
        selAddr   = '0;
        selWdata  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                selWrite  = req_write[i];
                selSize   = req_size[2*i +: 2];
                selSigned = req_signed[i];
                selAddr   = req_addr[i*ADDR_W +: ADDR_W];
                selWdata  = req_wdata[32*i +: 32];
            end
        end
    end

    // Next-state logic: accept in IDLE, wait out the slave in ISSUE, respond once.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ch_d     = ch_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (idleOpen && grantAny) begin
                    ch_d     = grantIdx;
                    addr_d   = selAddr;
                    size_d   = size_t'(selSize);
                    write_d  = selWrite;
                    signed_d = selSigned;
                    wdata_d  = selWdata;
                    ptr_d    = (grantIdx == IW'(N_CH - 1)) ? '0 : grantIdx + 1'b1;
                    state_d  = access_err(size_t'(selSize), selAddr[1:0]) ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!waitrequest) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            ch_q     <= '0;
            addr_q   <= '0;
            size_q   <= SZ_B;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ch_q     <= ch_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
        end
    end

    // Bus and response outputs decoded from state; held stable through waitrequest.
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        rsp_valid  = '0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        busy       = (state_q != ST_IDLE);
        if (state_q == ST_ISSUE) begin
            read       = !write_q;
            write      = write_q;
            address    = {addr_q[ADDR_W-1:2], 2'b00};
            byteenable = be_gen(size_q, addr_q[1:0]);
            writedata  = write_q ? store_steer(wdata_q, size_q) : '0;
        end
        if (!reset && (state_q == ST_RESP || state_q == ST_ERR)) begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_q == IW'(i)) begin
                    rsp_valid[i] = 1'b1;
                end
            end
            rsp_err = (state_q == ST_ERR);
            if (state_q == ST_RESP && !write_q) begin
                rsp_rdata = load_extract(readdata, size_q, addr_q[1:0], signed_q);
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_master_arb.sv
// Scoreboard bench for the bus master: a monitor predicts grants and responses
// from plain arithmetic rules and checks strobes, lanes, data and latency.
module tb_mips_bus_master_arb;

    localparam int N_CH   = 2;
    localparam int ADDR_W = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH-1:0]        req_write;
    logic [2*N_CH-1:0]      req_size;
    logic [N_CH-1:0]        req_signed;
    logic [ADDR_W*N_CH-1:0] req_addr;
    logic [32*N_CH-1:0]     req_wdata;
    logic [N_CH-1:0]        rsp_valid;
    logic                   rsp_err;
    logic [31:0]            rsp_rdata;
    logic [ADDR_W-1:0]      address;
    logic                   read;
    logic                   write;
    logic [31:0]            writedata;
    logic [3:0]             byteenable;
    logic                   waitrequest;
    logic [31:0]            readdata;
    logic                   busy;

    logic [N_CH-1:0]        fixReady;
    logic [N_CH-1:0]        fixRspValid;
    logic                   fixRspErr;
    logic [31:0]            fixRspRdata;
    logic [ADDR_W-1:0]      fixAddress;
    logic                   fixRead;
    logic                   fixWrite;
    logic [31:0]            fixWritedata;
    logic [3:0]             fixBe;
    logic                   fixBusy;

    typedef struct {
        int          ch;
        bit          err;
        bit          isWrite;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          acceptCyc;
        int          waits;
        int          strobes;
    } txn_t;

    txn_t sbQ[$];
    int   grantLog[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   modelPtr = 0;
    int   stallLeft = 0;
    int   fixGrantCnt = 0;

    logic [N_CH-1:0] monExpReady;
    logic [N_CH-1:0] monLowest;
    int              monCh;
    logic [1:0]      monSize;
    logic [31:0]     monAddr;
    txn_t            monTxn;

    mips_bus_master_arb #(.N_CH(N_CH), .ADDR_W(ADDR_W), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .address(address), .read(read),
        .write(write), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata), .busy(busy)
    );

    mips_bus_master_arb #(.N_CH(N_CH), .ADDR_W(ADDR_W), .ROUND_ROBIN(1'b0)) dutFix (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(fixReady),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(fixRspValid),
        .rsp_err(fixRspErr), .rsp_rdata(fixRspRdata), .address(fixAddress), .read(fixRead),
        .write(fixWrite), .writedata(fixWritedata), .byteenable(fixBe),
        .waitrequest(waitrequest), .readdata(readdata), .busy(fixBusy)
    );

    // Free-running clock and cycle counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference rules for a sub-word access, written as plain arithmetic.
    function automatic bit expErr(input logic [1:0] size, input logic [1:0] a);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (a % 2) != 0;
        if (size == 2'd2) return a != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] expBe(input logic [1:0] size, input logic [1:0] a);
        if (size == 2'd0) return 4'(1 << a);
        if (size == 2'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] expWdata(input logic [31:0] w, input logic [1:0] size);
        if (size == 2'd0) return {24'h0, w[7:0]} * 32'h01010101;
        if (size == 2'd1) return {16'h0, w[15:0]} * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] expRdata(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] a, input bit sgn);
        logic [31:0] s;
        logic [31:0] v;
        s = word >> (8 * a);
        if (size == 2'd0) begin
            v = s & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = s & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flagFailure(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endtask

    // Slave model: stall a configured number of strobe cycles, then complete.
    always @(posedge clk) begin
        #1;
        if ((read || write) && stallLeft > 0) begin
            waitrequest = 1'b1;
            stallLeft   = stallLeft - 1;
        end else begin
            waitrequest = 1'b0;
        end
    end

    // Monitor: predict grants, check bus strobes, score responses, log accepts.
    always @(negedge clk) begin
        if (reset) begin
            sbQ.delete();
            modelPtr = 0;
        end else begin
            monExpReady = '0;
            if (sbQ.size() == 0) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (monExpReady == '0 && req_valid[(modelPtr + k) % N_CH])
                        monExpReady[(modelPtr + k) % N_CH] = 1'b1;
                end
            end
            checkOutput("req_ready", 32'(req_ready), 32'(monExpReady));

            if (fixReady != '0) begin
                monLowest = '0;
                for (int k = N_CH - 1; k >= 0; k--) begin
                    if (req_valid[k]) monLowest = N_CH'(1 << k);
                end
                checkOutput("fixed_grant", 32'(fixReady), 32'(monLowest));
                fixGrantCnt++;
            end

            if (read || write) begin
                checkOutput("read_and_write", 32'(read & write), 32'h0);
                if (sbQ.size() == 0) begin
                    flagFailure("strobe_without_request");
                end else begin
                    if (sbQ[0].err) flagFailure("strobe_on_error");
                    checkOutput("address", address, sbQ[0].addr & 32'hFFFFFFFC);
                    checkOutput("byteenable", 32'(byteenable), 32'(sbQ[0].be));
                    checkOutput("write_strobe", 32'(write), 32'(sbQ[0].isWrite));
                    if (sbQ[0].isWrite) checkOutput("writedata", writedata, sbQ[0].wdata);
                    sbQ[0].strobes = sbQ[0].strobes + 1;
                    if (waitrequest) sbQ[0].waits = sbQ[0].waits + 1;
                end
            end

            if (rsp_valid != '0) begin
                if (sbQ.size() == 0) begin
                    flagFailure("rsp_without_request");
                end else begin
                    monTxn = sbQ.pop_front();
                    checkOutput("rsp_valid", 32'(rsp_valid), 32'(1 << monTxn.ch));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(monTxn.err));
                    checkOutput("rsp_rdata", rsp_rdata, monTxn.rdata);
                    checkOutput("latency", 32'(cyc - monTxn.acceptCyc),
                                32'(monTxn.err ? 1 : 2 + monTxn.waits));
                    checkOutput("strobe_cycles", 32'(monTxn.strobes),
                                32'(monTxn.err ? 0 : monTxn.waits + 1));
                end
            end

            if ((req_ready & req_valid) != '0) begin
                monCh = 0;
                for (int k = 0; k < N_CH; k++) begin
                    if (req_ready[k] && req_valid[k]) monCh = k;
                end
                monSize          = req_size[2*monCh +: 2];
                monAddr          = req_addr[ADDR_W*monCh +: ADDR_W];
                monTxn.ch        = monCh;
                monTxn.err       = expErr(monSize, monAddr[1:0]);
                monTxn.isWrite   = req_write[monCh];
                monTxn.addr      = monAddr;
                monTxn.be        = expBe(monSize, monAddr[1:0]);
                monTxn.wdata     = expWdata(req_wdata[32*monCh +: 32], monSize);
                monTxn.rdata     = (monTxn.err || monTxn.isWrite) ? 32'h0 :
                                   expRdata(readdata, monSize, monAddr[1:0], req_signed[monCh]);
                monTxn.acceptCyc = cyc;
                monTxn.waits     = 0;
                monTxn.strobes   = 0;
                sbQ.push_back(monTxn);
                grantLog.push_back(monCh);
                modelPtr = (monCh + 1) % N_CH;
            end
        end
    end

    task automatic waitIdle();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clk);
            #2;
            if (!busy && sbQ.size() == 0) got = 1'b1;
        end
        if (!got) flagFailure("completion_timeout");
    endtask

    // Present one request on a single channel, hold it until accepted, then drop it.
    task automatic applyStimulus(input int ch, input bit wr, input logic [1:0] size, input bit sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] word, input int stalls, input bit waitDone);
        bit got;
        @(posedge clk);
        #1;
        readdata                  = word;
        stallLeft                 = stalls;
        req_write[ch]             = wr;
        req_size[2*ch +: 2]       = size;
        req_signed[ch]            = sgn;
        req_addr[ADDR_W*ch +: ADDR_W] = addr;
        req_wdata[32*ch +: 32]    = wdata;
        req_valid[ch]             = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (req_ready[ch]) got = 1'b1;
        end
        if (!got) flagFailure("accept_timeout");
        @(posedge clk);
        #1;
        req_valid[ch] = 1'b0;
        if (waitDone) waitIdle();
    endtask

    // Hold both channels valid until the requested number of accepts has been logged.
    task automatic runBoth(input int nAccepts);
        int  base;
        bit  got;
        base = grantLog.size();
        @(posedge clk);
        #1;
        readdata      = 32'hCAFE0042;
        stallLeft     = 0;
        req_write     = 2'b10;
        req_size      = 4'b1010;
        req_signed    = 2'b00;
        req_addr      = {32'h0000_0204, 32'h0000_0100};
        req_wdata     = {32'h0000_55AA, 32'h0};
        req_valid     = 2'b11;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge clk);
            #1;
            if (grantLog.size() >= base + nAccepts) got = 1'b1;
        end
        req_valid = 2'b00;
        if (!got) flagFailure("both_valid_timeout");
        waitIdle();
    endtask

    int          base4;
    int          fixBase;
    logic [1:0]  rSize;
    logic [31:0] rAddr;

    // Main sequence: reset checks, directed cases, arbitration, reset abort, random.
    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_size    = '0;
        req_signed  = '0;
        req_addr    = '0;
        req_wdata   = '0;
        readdata    = '0;
        waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_read", 32'(read), 32'h0);
        checkOutput("reset_write", 32'(write), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_address", address, 32'h0);
        checkOutput("reset_writedata", writedata, 32'h0);
        checkOutput("reset_byteenable", 32'(byteenable), 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 0, 1'b1);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h2003, 32'h0, 32'h80112233, 0, 1'b1);
        applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h2003, 32'h0, 32'h80112233, 0, 1'b1);
        applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h80112233, 0, 1'b1);
        applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h3002, 32'h0000ABCD, 32'h0, 3, 1'b1);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 32'h11111111, 0, 1'b1);
        applyStimulus(1, 1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 32'h22222222, 0, 1'b1);

        base4   = grantLog.size();
        fixBase = fixGrantCnt;
        runBoth(4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rr_sequence", 32'(grantLog[base4 + i]), 32'(i % 2));
        end
        checkOutput("fixed_grant_count", 32'(fixGrantCnt - fixBase), 32'd4);

        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h12345678, 20, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_read", 32'(read), 32'h0);
        checkOutput("abort_write", 32'(write), 32'h0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        stallLeft = 0;
        base4 = grantLog.size();
        runBoth(2);
        checkOutput("post_reset_first_grant", 32'(grantLog[base4]), 32'h0);

        for (int t = 0; t < 40; t++) begin
            rSize = 2'($urandom_range(0, 3));
            rAddr = $urandom & 32'h0000FFFF;
            if ($urandom_range(0, 3) != 0) begin
                if (rSize == 2'd1) rAddr[0] = 1'b0;
                if (rSize == 2'd2) rAddr[1:0] = 2'b00;
            end
            applyStimulus($urandom_range(0, 1), 1'($urandom_range(0, 1)), rSize,
                          1'($urandom_range(0, 1)), rAddr, $urandom, $urandom,
                          $urandom_range(0, 2), 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
